// File: rtl/output_requant_packer.sv
// rtl/output_requant_packer.sv - int32 accumulator requantiser and int8 word packer
//
// Takes one int32 accumulator per cycle. Each element is rescaled by a Q31
// multiplier (rounding doubling high multiply, stage A). It is then divided by
// 2^shift with round-half-away-from-zero, offset by the output zero-point and
// clamped to the activation range (stage B). The int8 results are packed into
// 32-bit words, with lane 0 in bits [7:0].
//
// Configuration macro: PACKER_STAGE_REG_EN
//   undefined : stages A and B are evaluated in the same cycle after the input
//               register (2-cycle latency from acceptance to out_valid)
//   defined   : an extra register sits between stage A and stage B
//               (3-cycle latency); arithmetic is identical
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous active-low reset
//   in_valid / in_ready     element handshake
//   in_acc                  signed int32 accumulator
//   in_mult                 signed Q31 multiplier
//   in_shift                right shift 0..SHIFT_MAX (larger values saturate)
//   in_offset               signed output zero-point
//   in_act_min/in_act_max   signed int8 clamp bounds
//   in_last                 element closes the current word
//   out_valid / out_ready   word handshake
//   out_word                four int8 lanes; unused lanes of a partial word are 0
//   out_lanes               number of valid lanes, 1..4

module output_requant_packer #(
    parameter int SHIFT_MAX = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_acc,
    input  logic [31:0] in_mult,
    input  logic [4:0]  in_shift,
    input  logic [31:0] in_offset,
    input  logic [7:0]  in_act_min,
    input  logic [7:0]  in_act_max,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [2:0]  out_lanes
);

    localparam logic [5:0] SHIFT_CAP = 6'(SHIFT_MAX);

    // ------------------------------------------------------------------
    // Flow control: only a pending lane write into a held word stalls.
    // ------------------------------------------------------------------
    logic handshake;
    logic stall;
    logic advance;
    logic b_valid;

    assign handshake = out_valid && out_ready;
    assign stall     = out_valid && !out_ready && b_valid;
    assign advance   = !stall;
    assign in_ready  = advance;

    // ------------------------------------------------------------------
    // Input register: the element and its control fields travel together.
    // ------------------------------------------------------------------
    logic [4:0]         shift_sat;
    logic               p1_valid;
    logic signed [31:0] p1_acc;
    logic signed [31:0] p1_mult;
    logic [4:0]         p1_shift;
    logic signed [31:0] p1_offset;
    logic signed [7:0]  p1_min;
    logic signed [7:0]  p1_max;
    logic               p1_last;

    always_comb begin
        shift_sat = in_shift;
        if ({1'b0, in_shift} > SHIFT_CAP) begin
            shift_sat = SHIFT_CAP[4:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_valid  <= 1'b0;
            p1_acc    <= '0;
            p1_mult   <= '0;
            p1_shift  <= '0;
            p1_offset <= '0;
            p1_min    <= '0;
            p1_max    <= '0;
            p1_last   <= 1'b0;
        end else if (advance) begin
            p1_valid  <= in_valid;
            p1_acc    <= in_acc;
            p1_mult   <= in_mult;
            p1_shift  <= shift_sat;
            p1_offset <= in_offset;
            p1_min    <= in_act_min;
            p1_max    <= in_act_max;
            p1_last   <= in_last;
        end
    end

    // ------------------------------------------------------------------
    // Stage A: saturating rounding doubling high multiply.
    // ------------------------------------------------------------------
    logic signed [63:0] prod;
    logic signed [63:0] nudged;
    logic signed [63:0] toward_zero;
    logic [31:0]        rdh_a;
    logic               unused_rdh_bits;

    always_comb begin
        prod   = 64'(p1_acc) * 64'(p1_mult);
        nudged = prod + (prod[63] ? -64'sd1073741823 : 64'sd1073741824);
        // Divide by 2^31 truncating toward zero: bias negatives before the shift.
        toward_zero = nudged[63] ? (nudged + 64'sd2147483647) : nudged;
        if ((p1_acc == 32'sh80000000) && (p1_mult == 32'sh80000000)) begin
            rdh_a = 32'h7FFFFFFF;
        end else begin
            rdh_a = toward_zero[62:31];
        end
    end

    assign unused_rdh_bits = ^{toward_zero[63], toward_zero[30:0]};

    // ------------------------------------------------------------------
    // Stage B operand source
    // ------------------------------------------------------------------
    logic [31:0]        b_rdh;
    logic [4:0]         b_shift;
    logic signed [31:0] b_offset;
    logic signed [7:0]  b_min;
    logic signed [7:0]  b_max;
    logic               b_last;

`ifdef PACKER_STAGE_REG_EN
    logic               p2_valid;
    logic [31:0]        p2_rdh;
    logic [4:0]         p2_shift;
    logic signed [31:0] p2_offset;
    logic signed [7:0]  p2_min;
    logic signed [7:0]  p2_max;
    logic               p2_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p2_valid  <= 1'b0;
            p2_rdh    <= '0;
            p2_shift  <= '0;
            p2_offset <= '0;
            p2_min    <= '0;
            p2_max    <= '0;
            p2_last   <= 1'b0;
        end else if (advance) begin
            p2_valid  <= p1_valid;
            p2_rdh    <= rdh_a;
            p2_shift  <= p1_shift;
            p2_offset <= p1_offset;
            p2_min    <= p1_min;
            p2_max    <= p1_max;
            p2_last   <= p1_last;
        end
    end

    assign b_valid  = p2_valid;
    assign b_rdh    = p2_rdh;
    assign b_shift  = p2_shift;
    assign b_offset = p2_offset;
    assign b_min    = p2_min;
    assign b_max    = p2_max;
    assign b_last   = p2_last;
`else
    assign b_valid  = p1_valid;
    assign b_rdh    = rdh_a;
    assign b_shift  = p1_shift;
    assign b_offset = p1_offset;
    assign b_min    = p1_min;
    assign b_max    = p1_max;
    assign b_last   = p1_last;
`endif

    // ------------------------------------------------------------------
    // Stage B: rounding right shift, zero-point, clamp.
    // ------------------------------------------------------------------
    logic [31:0]        mask;
    logic [31:0]        rem;
    logic [31:0]        thr;
    logic signed [31:0] shifted;
    logic signed [33:0] sum_b;
    logic [7:0]         lane_val;

    always_comb begin
        mask    = (32'd1 << b_shift) - 32'd1;
        rem     = b_rdh & mask;
        // Negative values need a strictly larger remainder to round up,
        // which makes exact halves round away from zero.
        thr     = (mask >> 1) + {31'd0, b_rdh[31]};
        shifted = $signed(b_rdh) >>> b_shift;
        sum_b   = $signed(34'(shifted) + 34'(b_offset) + {33'd0, (rem > thr)});
        if (sum_b > 34'(b_max)) begin
            lane_val = b_max;
        end else if (sum_b < 34'(b_min)) begin
            lane_val = b_min;
        end else begin
            lane_val = sum_b[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Word buffer. The buffer doubles as the output register, so a closed
    // word blocks further lane writes until it is taken. A handshake clears
    // it, and a lane write in the same cycle lands in the cleared buffer.
    // ------------------------------------------------------------------
    logic [1:0]  lane_cnt;
    logic [1:0]  lane_cnt_n;
    logic [31:0] word_n;
    logic        valid_n;
    logic [2:0]  lanes_n;
    logic        close;

    assign close = (lane_cnt == 2'd3) || b_last;

    always_comb begin
        word_n     = out_word;
        valid_n    = out_valid;
        lanes_n    = out_lanes;
        lane_cnt_n = lane_cnt;
        if (handshake) begin
            word_n  = '0;
            valid_n = 1'b0;
            lanes_n = '0;
        end
        if (b_valid && !stall) begin
            word_n[{lane_cnt, 3'b000} +: 8] = lane_val;
            if (close) begin
                valid_n    = 1'b1;
                lanes_n    = {1'b0, lane_cnt} + 3'd1;
                lane_cnt_n = 2'd0;
            end else begin
                lane_cnt_n = lane_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            out_lanes <= '0;
            lane_cnt  <= '0;
        end else begin
            out_valid <= valid_n;
            out_word  <= word_n;
            out_lanes <= lanes_n;
            lane_cnt  <= lane_cnt_n;
        end
    end

endmodule

// File: tb/tb_output_requant_packer.sv
// tb/tb_output_requant_packer.sv - directed self-checking bench for output_requant_packer

module tb_output_requant_packer;

`ifdef PACKER_STAGE_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic [31:0] in_mult = '0;
    logic [4:0]  in_shift = '0;
    logic [31:0] in_offset = '0;
    logic [7:0]  in_act_min = '0;
    logic [7:0]  in_act_max = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [2:0]  out_lanes;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_word[$];
    logic [2:0]  q_lanes[$];

    output_requant_packer #(.SHIFT_MAX(31)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_acc     (in_acc),
        .in_mult    (in_mult),
        .in_shift   (in_shift),
        .in_offset  (in_offset),
        .in_act_min (in_act_min),
        .in_act_max (in_act_max),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_lanes  (out_lanes)
    );

    always #5 clk = ~clk;

    // Record every word that will be taken on the coming rising edge.
    always @(negedge clk) begin
        #2;
        if (reset && out_valid && out_ready) begin
            q_word.push_back(out_word);
            q_lanes.push_back(out_lanes);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] acc, input logic [31:0] mult, input logic [4:0] sh,
                        input logic [31:0] off, input logic [7:0] mn, input logic [7:0] mx,
                        input logic last);
        bit ok = 1'b0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_acc     = acc;
        in_mult    = mult;
        in_shift   = sh;
        in_offset  = off;
        in_act_min = mn;
        in_act_max = mx;
        in_last    = last;
        for (int n = 0; n < 100 && !ok; n++) begin
            #4;
            if (in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            check_val("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic simple(input logic [31:0] acc, input logic last);
        send(acc, 32'h7FFFFFFF, 5'd0, 32'd0, 8'h80, 8'h7F, last);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic [2:0] l);
        int n = 0;
        while (q_word.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q_word.size() == 0) begin
            check_val({tag, "_timeout"}, 32'(q_word.size()), 32'd1);
        end else begin
            check_val({tag, "_word"}, q_word.pop_front(), w);
            check_val({tag, "_lanes"}, 32'(q_lanes.pop_front()), 32'(l));
        end
    endtask

    initial begin
        int n;
        int stable;
        int dropped;
        logic [31:0] w0;
        logic [2:0]  l0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_word", out_word, 32'd0);
        check_val("rst_out_lanes", 32'(out_lanes), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // rdh(100, 2^30) = 50, >>1 = 25, -128 -> -103 = 0x99; also latency
        send(32'd100, 32'h40000000, 5'd1, -32'sd128, 8'h80, 8'h7F, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end while (!out_valid && n < 10);
        check_val("latency", n, LAT);
        expect_word("basic", 32'h00000099, 3'd1);

        // INT32_MIN * INT32_MIN saturates to INT32_MAX, clamped to 127
        send(32'h80000000, 32'h80000000, 5'd0, 32'd0, 8'h80, 8'h7F, 1'b1);
        idle();
        expect_word("sat", 32'h0000007F, 3'd1);

        // Burst of 5, last on the fifth
        for (int i = 1; i <= 5; i++) simple(32'(i), i == 5);
        idle();
        expect_word("burst_w0", 32'h04030201, 3'd4);
        expect_word("burst_w1", 32'h00000005, 3'd1);

        // -5 >> 1 -> -3, 5 >> 1 -> 3
        send(-32'sd5, 32'h7FFFFFFF, 5'd1, 32'd0, 8'h80, 8'h7F, 1'b0);
        send(32'd5, 32'h7FFFFFFF, 5'd1, 32'd0, 8'h80, 8'h7F, 1'b1);
        idle();
        expect_word("half", 32'h000003FD, 3'd2);

        // shift 3: -12 -> -2, -13 -> -2, -11 -> -1, 12 -> 2; lane 3 closes
        send(-32'sd12, 32'h7FFFFFFF, 5'd3, 32'd0, 8'h80, 8'h7F, 1'b0);
        send(-32'sd13, 32'h7FFFFFFF, 5'd3, 32'd0, 8'h80, 8'h7F, 1'b0);
        send(-32'sd11, 32'h7FFFFFFF, 5'd3, 32'd0, 8'h80, 8'h7F, 1'b0);
        send(32'd12, 32'h7FFFFFFF, 5'd3, 32'd0, 8'h80, 8'h7F, 1'b0);
        idle();
        expect_word("shift3", 32'h02FFFEFE, 3'd4);

        // offset 5, clamp [-10, 10]: 55 -> 10, -45 -> -10, 8 -> 8
        send(32'd50, 32'h7FFFFFFF, 5'd0, 32'd5, 8'hF6, 8'h0A, 1'b0);
        send(-32'sd50, 32'h7FFFFFFF, 5'd0, 32'd5, 8'hF6, 8'h0A, 1'b0);
        send(32'd3, 32'h7FFFFFFF, 5'd0, 32'd5, 8'hF6, 8'h0A, 1'b1);
        idle();
        expect_word("clamp", 32'h0008F60A, 3'd3);

        // Back-pressure for 10 cycles with a continuous stream
        @(negedge clk);
        out_ready = 1'b0;
        stable  = 1;
        dropped = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) simple(32'(11 + i), i == 7);
                idle();
            end
            begin
                n = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                w0 = out_word;
                l0 = out_lanes;
                check_val("stall_held_word", w0, 32'h0E0D0C0B);
                repeat (10) begin
                    @(negedge clk);
                    if (out_word !== w0 || out_lanes !== l0 || !out_valid) stable = 0;
                    if (!in_ready) dropped = 1;
                end
                check_val("stall_stable", stable, 1);
                check_val("stall_in_ready_drop", dropped, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        expect_word("stall_w0", 32'h0E0D0C0B, 3'd4);
        expect_word("stall_w1", 32'h1211100F, 3'd4);
        repeat (5) @(negedge clk);
        check_val("stall_no_extra", 32'(q_word.size()), 32'd0);

        // Reset with elements in flight
        out_ready = 1'b0;
        simple(32'd7, 1'b0);
        simple(32'd8, 1'b1);
        simple(32'd9, 1'b0);
        idle();
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("pre_rst_word", out_word, 32'h00000807);
        reset = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'd0);
        check_val("async_rst_word", out_word, 32'd0);
        check_val("async_rst_lanes", 32'(out_lanes), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);
        q_word.delete();
        q_lanes.delete();
        out_ready = 1'b1;
        simple(32'd10, 1'b1);
        idle();
        expect_word("post_rst", 32'h0000000A, 3'd1);
        repeat (5) @(negedge clk);
        check_val("post_rst_no_extra", 32'(q_word.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 0x00000001 exp 0x00000000");
        $fatal(1, "timeout");
    end

endmodule
